// File: rtl/cc_branch_ctrl.sv
// Condition-code owner: N/Z/P loads from the bus, BEN evaluation for BR,
// and an NZP shadow stack saved on interrupt entry and restored on RTI.
module cc_branch_ctrl #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SP_W        = 3
) (
  input  logic            i_CLK,
  input  logic            i_RST_N,
  input  logic            i_LD_CC_Control,
  input  logic [15:0]     i_Bus,
  input  logic            i_LD_BEN,
  input  logic [2:0]      i_IR_NZP,
  input  logic            i_CC_Push,
  input  logic            i_CC_Pop,
  input  logic            i_Err_Clr,
  output logic [2:0]      o_NZP,
  output logic            o_BEN,
  output logic [SP_W-1:0] o_Depth,
  output logic            o_Full,
  output logic            o_Empty,
  output logic            o_Overflow,
  output logic            o_Underflow
);

  localparam int unsigned NZP_W = 3;
  localparam int unsigned IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [NZP_W-1:0] NZP_RESET = 3'b010;

  logic [NZP_W-1:0] stack_q [STACK_DEPTH];

  logic [NZP_W-1:0] cc_bus_c;
  logic             push_ok_c;
  logic             pop_ok_c;
  logic [NZP_W-1:0] nzp_d;
  logic             ben_d;
  logic [SP_W-1:0]  depth_d;
  logic             ovf_d;
  logic             unf_d;
  logic             stack_we_c;
  logic [IDX_W-1:0] push_idx_c;
  logic [IDX_W-1:0] pop_idx_c;

  // Full/empty decode straight off the depth counter
  assign o_Full  = (o_Depth == SP_W'(STACK_DEPTH));
  assign o_Empty = (o_Depth == '0);

  // Next-state: CC decode, pop > push > load priority, BEN and sticky flags
  always_comb begin
    cc_bus_c   = {i_Bus[15], (i_Bus == 16'h0000), (~i_Bus[15] & (i_Bus != 16'h0000))};
    pop_ok_c   = i_CC_Pop & ~o_Empty;
    push_ok_c  = i_CC_Push & ~i_CC_Pop & ~o_Full;
    push_idx_c = IDX_W'(o_Depth);
    pop_idx_c  = IDX_W'(o_Depth - SP_W'(1));
    stack_we_c = push_ok_c;

    nzp_d   = o_NZP;
    depth_d = o_Depth;
    ben_d   = o_BEN;
    ovf_d   = o_Overflow & ~i_Err_Clr;
    unf_d   = o_Underflow & ~i_Err_Clr;

    if (i_CC_Pop) begin
      if (pop_ok_c) begin
        nzp_d   = stack_q[pop_idx_c];
        depth_d = o_Depth - SP_W'(1);
      end else begin
        unf_d = 1'b1;
      end
    end else if (i_CC_Push) begin
      if (push_ok_c) begin
        nzp_d   = NZP_RESET;
        depth_d = o_Depth + SP_W'(1);
      end else begin
        ovf_d = 1'b1;
      end
    end else if (i_LD_CC_Control) begin
      nzp_d = cc_bus_c;
    end

    if (i_LD_BEN) begin
      ben_d = |(i_IR_NZP & o_NZP);
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge i_CLK) begin
    if (!i_RST_N) begin
      o_NZP       <= NZP_RESET;
      o_BEN       <= 1'b0;
      o_Depth     <= '0;
      o_Overflow  <= 1'b0;
      o_Underflow <= 1'b0;
      for (int i = 0; i < int'(STACK_DEPTH); i++) begin
        stack_q[i] <= '0;
      end
    end else begin
      o_NZP       <= nzp_d;
      o_BEN       <= ben_d;
      o_Depth     <= depth_d;
      o_Overflow  <= ovf_d;
      o_Underflow <= unf_d;
      if (stack_we_c) begin
        stack_q[push_idx_c] <= o_NZP;
      end
    end
  end

endmodule

// File: tb/tb_cc_branch_ctrl.sv
// Directed bench for cc_branch_ctrl: vector table plus multi-cycle sequences.
module tb_cc_branch_ctrl;

  localparam int unsigned STACK_DEPTH = 4;
  localparam int unsigned SP_W        = 3;

  logic            clk;
  logic            rst_n;
  logic            ld_cc;
  logic [15:0]     bus;
  logic            ld_ben;
  logic [2:0]      ir_nzp;
  logic            push;
  logic            pop;
  logic            err_clr;
  logic [2:0]      nzp;
  logic            ben;
  logic [SP_W-1:0] depth;
  logic            full;
  logic            empty;
  logic            ovf;
  logic            unf;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        ld_cc;
    logic [15:0] bus;
    logic        ld_ben;
    logic [2:0]  ir;
    logic        push;
    logic        pop;
    logic        clr;
    logic [2:0]  e_nzp;
    logic        e_ben;
    logic [2:0]  e_depth;
    logic        e_ovf;
    logic        e_unf;
  } vec_t;

  vec_t vecs[$];

  cc_branch_ctrl #(.STACK_DEPTH(STACK_DEPTH), .SP_W(SP_W)) dut (
    .i_CLK           (clk),
    .i_RST_N         (rst_n),
    .i_LD_CC_Control (ld_cc),
    .i_Bus           (bus),
    .i_LD_BEN        (ld_ben),
    .i_IR_NZP        (ir_nzp),
    .i_CC_Push       (push),
    .i_CC_Pop        (pop),
    .i_Err_Clr       (err_clr),
    .o_NZP           (nzp),
    .o_BEN           (ben),
    .o_Depth         (depth),
    .o_Full          (full),
    .o_Empty         (empty),
    .o_Overflow      (ovf),
    .o_Underflow     (unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic chk_state(input string tag, input logic [2:0] e_nzp, input logic e_ben,
                           input logic [2:0] e_depth, input logic e_ovf, input logic e_unf);
    chk({tag, "_nzp"},   int'(nzp),   int'(e_nzp));
    chk({tag, "_ben"},   int'(ben),   int'(e_ben));
    chk({tag, "_depth"}, int'(depth), int'(e_depth));
    chk({tag, "_full"},  int'(full),  int'(e_depth == 3'(STACK_DEPTH)));
    chk({tag, "_empty"}, int'(empty), int'(e_depth == 3'd0));
    chk({tag, "_ovf"},   int'(ovf),   int'(e_ovf));
    chk({tag, "_unf"},   int'(unf),   int'(e_unf));
  endtask

  // One clock with the given inputs; outputs sampled 1ns after the edge
  task automatic step(input logic a_ld_cc, input logic [15:0] a_bus, input logic a_ld_ben,
                      input logic [2:0] a_ir, input logic a_push, input logic a_pop,
                      input logic a_clr);
    ld_cc   = a_ld_cc;
    bus     = a_bus;
    ld_ben  = a_ld_ben;
    ir_nzp  = a_ir;
    push    = a_push;
    pop     = a_pop;
    err_clr = a_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0;
    ld_cc = 1'b0; bus = '0; ld_ben = 1'b0; ir_nzp = '0;
    push = 1'b0; pop = 1'b0; err_clr = 1'b0;

    // Reset state
    @(negedge clk);
    step(1'b1, 16'h8000, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
    chk_state("reset", 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;

    //          ldcc  bus       ldben ir      push  pop   clr   nzp     ben   dep   ovf   unf
    vecs.push_back('{1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b010, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h7FFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 3'b011, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0, 3'b001, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b010, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'hFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0005, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1, 3'b100, 1'b1, 3'd0, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h0001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b1, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h8000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'd2, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b001, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 3'b100, 1'b0, 3'd0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b1, 3'b100, 1'b1, 1'b0, 1'b0, 3'b010, 1'b1, 3'd1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 3'b100, 1'b1, 3'd0, 1'b0, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].ld_cc, vecs[i].bus, vecs[i].ld_ben, vecs[i].ir,
           vecs[i].push, vecs[i].pop, vecs[i].clr);
      chk_state($sformatf("v%0d", i), vecs[i].e_nzp, vecs[i].e_ben,
                vecs[i].e_depth, vecs[i].e_ovf, vecs[i].e_unf);
    end

    // Fill the stack with distinct snapshots 100, 001, 010, 100, then overflow
    step(1'b1, 16'h8000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b1, 16'h7FFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk_state("fill3", 3'b010, 1'b1, 3'd3, 1'b0, 1'b0);
    step(1'b1, 16'hFFFF, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk_state("fill4", 3'b010, 1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b1, 16'h8000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk_state("push5_ovf", 3'b010, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    chk_state("ovf_clr", 3'b010, 1'b1, 3'd4, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    chk_state("ovf_clr_race", 3'b010, 1'b1, 3'd4, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);

    // LIFO restore
    begin
      logic [2:0] lifo [4];
      lifo[0] = 3'b100; lifo[1] = 3'b010; lifo[2] = 3'b001; lifo[3] = 3'b100;
      for (int k = 0; k < 4; k++) begin
        step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0);
        chk_state($sformatf("lifo%0d", k), lifo[k], 1'b1, 3'(3 - k), 1'b0, 1'b0);
      end
    end

    // Depth 3 with overflow set and BEN high, then reset with push asserted
    for (int k = 0; k < 5; k++) step(1'b0, 16'h0000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 3'b010, 1'b0, 1'b1, 1'b0);
    chk_state("pre_rst", 3'b010, 1'b1, 3'd3, 1'b1, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 16'h8000, 1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
    chk_state("mid_rst", 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
    idle();
    chk_state("post_rst", 3'b010, 1'b0, 3'd0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
